arcade_input_ctrl: RTL and testbench

- Input-conditioning stage between hps_io (ps2_key, joystick_0/1) and the game core's control pins.
- Decodes PS/2 key toggle events into held key states and merges them with both joysticks into per-player control vectors.
- Generates a timed coin-then-start sequence from a single start press, replacing the combinational start-OR-coin hack.

---
 rtl/arcade_input_pkg.sv | 48 ++++
 rtl/arcade_input_ctrl_decoder.sv | 72 +++++++
 rtl/arcade_input_ctrl.sv | 162 ++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// Shared scancodes, control-vector bit positions and sequencer state type
// for the arcade input conditioning stage.
package arcade_input_pkg;

    // Arrow keys (accepted with or without the extended prefix)
    localparam logic [7:0] SC_UP          = 8'h75;
    localparam logic [7:0] SC_DOWN        = 8'h72;
    localparam logic [7:0] SC_LEFT        = 8'h6B;
    localparam logic [7:0] SC_RIGHT       = 8'h74;
    // Player 1, non-extended only
    localparam logic [7:0] SC_FIRE        = 8'h14;
    localparam logic [7:0] SC_PADL        = 8'h26;
    localparam logic [7:0] SC_PADR        = 8'h29;
    // Player 2, non-extended only
    localparam logic [7:0] SC_P2_UP       = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN     = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT     = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT    = 8'h34;
    localparam logic [7:0] SC_P2_FIRE     = 8'h1C;
    localparam logic [7:0] SC_P2_PADL     = 8'h1B;
    localparam logic [7:0] SC_P2_PADR     = 8'h15;
    // System keys, non-extended only
    localparam logic [7:0] SC_START1_A    = 8'h05;
    localparam logic [7:0] SC_START1_B    = 8'h16;
    localparam logic [7:0] SC_START2_A    = 8'h06;
    localparam logic [7:0] SC_START2_B    = 8'h1E;
    localparam logic [7:0] SC_COIN_A      = 8'h2E;
    localparam logic [7:0] SC_COIN_B      = 8'h36;
    localparam logic [7:0] SC_TEST        = 8'h2C;

    localparam int CTL_RIGHT = 0;
    localparam int CTL_LEFT  = 1;
    localparam int CTL_DOWN  = 2;
    localparam int CTL_UP    = 3;
    localparam int CTL_FIRE  = 4;
    localparam int CTL_PADL  = 5;
    localparam int CTL_PADR  = 6;
    localparam int CTL_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COIN,
        ST_GAP,
        ST_START,
        ST_RELEASE
    } seq_state_t;

endpackage

// File: rtl/arcade_input_ctrl_decoder.sv
// PS/2 toggle-event detector and held-key register bank.
module ps2_key_decoder
    import arcade_input_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic [6:0]  key_p1,
    output logic [6:0]  key_p2,
    output logic        key_start1,
    output logic        key_start2,
    output logic        key_coin,
    output logic        key_test
);

    logic       old_toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;

    assign pressed = ps2_key[9];
    assign ext     = ps2_key[8];
    assign code    = ps2_key[7:0];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // Track the current toggle so leaving reset never looks like an event
            old_toggle <= ps2_key[10];
            key_p1     <= '0;
            key_p2     <= '0;
            key_start1 <= 1'b0;
            key_start2 <= 1'b0;
            key_coin   <= 1'b0;
            key_test   <= 1'b0;
        end else begin
            old_toggle <= ps2_key[10];
            if (ps2_key[10] != old_toggle) begin
                case (code)
                    SC_UP:    key_p1[CTL_UP]    <= pressed;
                    SC_DOWN:  key_p1[CTL_DOWN]  <= pressed;
                    SC_LEFT:  key_p1[CTL_LEFT]  <= pressed;
                    SC_RIGHT: key_p1[CTL_RIGHT] <= pressed;
                    default: begin
                        if (!ext) begin
                            case (code)
                                SC_FIRE:     key_p1[CTL_FIRE]  <= pressed;
                                SC_PADL:     key_p1[CTL_PADL]  <= pressed;
                                SC_PADR:     key_p1[CTL_PADR]  <= pressed;
                                SC_P2_UP:    key_p2[CTL_UP]    <= pressed;
                                SC_P2_DOWN:  key_p2[CTL_DOWN]  <= pressed;
                                SC_P2_LEFT:  key_p2[CTL_LEFT]  <= pressed;
                                SC_P2_RIGHT: key_p2[CTL_RIGHT] <= pressed;
                                SC_P2_FIRE:  key_p2[CTL_FIRE]  <= pressed;
                                SC_P2_PADL:  key_p2[CTL_PADL]  <= pressed;
                                SC_P2_PADR:  key_p2[CTL_PADR]  <= pressed;
                                SC_START1_A,
                                SC_START1_B: key_start1        <= pressed;
                                SC_START2_A,
                                SC_START2_B: key_start2        <= pressed;
                                SC_COIN_A,
                                SC_COIN_B:   key_coin          <= pressed;
                                SC_TEST:     key_test          <= pressed;
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Merges PS/2 keys and joysticks into core control pins. Define
// ARCADE_AUTO_COIN_EN for the timed coin-then-start sequencer.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES  = 120000,
    parameter int GAP_CYCLES   = 600000,
    parameter int START_CYCLES = 120000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic [6:0]  p1_ctrl,
    output logic [6:0]  p2_ctrl,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        test,
    output logic        seq_busy
);

    logic [6:0] key_p1;
    logic [6:0] key_p2;
    logic       key_start1;
    logic       key_start2;
    logic       key_coin;
    logic       key_test;
    logic       req_s1;
    logic       req_s2;
    logic       unused_joy_bits;

    ps2_key_decoder u_decoder (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .key_p1     (key_p1),
        .key_p2     (key_p2),
        .key_start1 (key_start1),
        .key_start2 (key_start2),
        .key_coin   (key_coin),
        .key_test   (key_test)
    );

    assign req_s1          = key_start1 | joystick_0[7] | joystick_1[7];
    assign req_s2          = key_start2 | joystick_0[8] | joystick_1[8];
    assign unused_joy_bits = ^{joystick_0[15:9], joystick_1[15:9]};

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            p1_ctrl <= '0;
            p2_ctrl <= '0;
            test    <= 1'b0;
        end else begin
            p1_ctrl <= key_p1 | joystick_0[CTL_W-1:0];
            p2_ctrl <= key_p2 | joystick_1[CTL_W-1:0];
            test    <= key_test;
        end
    end

`ifdef ARCADE_AUTO_COIN_EN
    localparam int MAX_CYC = (COIN_CYCLES > GAP_CYCLES) ?
                             ((COIN_CYCLES > START_CYCLES) ? COIN_CYCLES : START_CYCLES) :
                             ((GAP_CYCLES > START_CYCLES) ? GAP_CYCLES : START_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             sel2;
    logic             sel2_nx;
    logic             req_any;
    logic             req_prev;

    assign req_any = req_s1 | req_s2;

    always_comb begin
        state_nx = state;
        sel2_nx  = sel2;
        cnt_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_any && !req_prev) begin
                    state_nx = ST_COIN;
                    sel2_nx  = !req_s1;
                    cnt_clr  = 1'b1;
                end
            end
            ST_COIN: begin
                if (cnt == COIN_LAST) begin
                    state_nx = ST_GAP;
                    cnt_clr  = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = ST_START;
                    cnt_clr  = 1'b1;
                end
            end
            ST_START: begin
                if (cnt == START_LAST) begin
                    state_nx = ST_RELEASE;
                    cnt_clr  = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!req_any) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change with the state register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sel2     <= 1'b0;
            req_prev <= 1'b0;
            start1   <= 1'b0;
            start2   <= 1'b0;
            coin1    <= 1'b0;
            seq_busy <= 1'b0;
        end else begin
            req_prev <= req_any;
            state    <= state_nx;
            sel2     <= sel2_nx;
            if (cnt_clr || state == ST_IDLE || state == ST_RELEASE)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            start1   <= (state_nx == ST_START) && !sel2_nx;
            start2   <= (state_nx == ST_START) && sel2_nx;
            coin1    <= (state_nx == ST_COIN) | key_coin;
            seq_busy <= (state_nx != ST_IDLE);
        end
    end
`else
    localparam int unused_cycles = COIN_CYCLES + GAP_CYCLES + START_CYCLES;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            start1 <= 1'b0;
            start2 <= 1'b0;
            coin1  <= 1'b0;
        end else begin
            start1 <= req_s1;
            start2 <= req_s2;
            coin1  <= key_coin;
        end
    end

    assign seq_busy = 1'b0;
`endif

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl: vector table, randomized run
// against a key-map model, and hand-written sequencer scenarios.
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic [6:0]  p1_ctrl;
    logic [6:0]  p2_ctrl;
    logic        start1;
    logic        start2;
    logic        coin1;
    logic        test;
    logic        seq_busy;

    int n_assert = 0;
    int n_fail   = 0;

    arcade_input_ctrl #(
        .COIN_CYCLES  (4),
        .GAP_CYCLES   (3),
        .START_CYCLES (5)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .p1_ctrl    (p1_ctrl),
        .p2_ctrl    (p2_ctrl),
        .start1     (start1),
        .start2     (start2),
        .coin1      (coin1),
        .test       (test),
        .seq_busy   (seq_busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Key map: function index 0..6 P1 ctrl bits, 7..13 P2 ctrl bits,
    // 14 start1, 15 start2, 16 coin, 17 test.
    localparam int NMAP = 21;
    logic [7:0] map_code [NMAP] = '{8'h75, 8'h72, 8'h6B, 8'h74,
                                    8'h14, 8'h26, 8'h29,
                                    8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15,
                                    8'h05, 8'h16, 8'h06, 8'h1E, 8'h2E, 8'h36, 8'h2C};
    bit         map_any  [NMAP] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0,
                                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int         map_fn   [NMAP] = '{3, 2, 1, 0, 4, 5, 6,
                                    10, 9, 8, 7, 11, 12, 13,
                                    14, 14, 15, 15, 16, 16, 17};

    logic [17:0] m_keys;
    logic        m_old;
    logic [6:0]  e_p1, e_p2;
    logic        e_s1, e_s2, e_coin, e_test;

    function automatic int lookup(logic ext, logic [7:0] code);
        for (int i = 0; i < NMAP; i++)
            if (map_code[i] == code && (map_any[i] || !ext)) return map_fn[i];
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the same edge as the DUT, compare after it.
    task automatic tick();
        int f;
        @(posedge clk_sys);
        if (!reset_n) begin
            m_keys = '0;
            m_old  = ps2_key[10];
            e_p1 = '0; e_p2 = '0; e_s1 = 0; e_s2 = 0; e_coin = 0; e_test = 0;
        end else begin
            e_p1   = m_keys[6:0]  | joystick_0[6:0];
            e_p2   = m_keys[13:7] | joystick_1[6:0];
            e_s1   = m_keys[14] | joystick_0[7] | joystick_1[7];
            e_s2   = m_keys[15] | joystick_0[8] | joystick_1[8];
            e_coin = m_keys[16];
            e_test = m_keys[17];
            if (ps2_key[10] != m_old) begin
                f = lookup(ps2_key[8], ps2_key[7:0]);
                if (f >= 0) m_keys[f] = ps2_key[9];
            end
            m_old = ps2_key[10];
        end
        #1;
        chk("p1_ctrl", 32'(p1_ctrl), 32'(e_p1));
        chk("p2_ctrl", 32'(p2_ctrl), 32'(e_p2));
        chk("test",    32'(test),    32'(e_test));
`ifndef ARCADE_AUTO_COIN_EN
        chk("start1",   32'(start1),   32'(e_s1));
        chk("start2",   32'(start2),   32'(e_s2));
        chk("coin1",    32'(coin1),    32'(e_coin));
        chk("seq_busy", 32'(seq_busy), 32'(0));
`endif
    endtask

    task automatic chk_sys(input string name, input logic c, input logic s1,
                           input logic s2, input logic busy);
        chk({name, ".coin1"},    32'(coin1),    32'(c));
        chk({name, ".start1"},   32'(start1),   32'(s1));
        chk({name, ".start2"},   32'(start2),   32'(s2));
        chk({name, ".seq_busy"}, 32'(seq_busy), 32'(busy));
    endtask

    task automatic do_reset(input int cycles);
        reset_n    = 1'b0;
        joystick_0 = '0;
        joystick_1 = '0;
        for (int i = 0; i < cycles; i++) tick();
        reset_n = 1'b1;
    endtask

`ifdef ARCADE_AUTO_COIN_EN
    // Inputs must already present a fresh start edge for the next clock.
    task automatic run_seq(input string name, input bit sel2, input bit poke);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk_sys(name, c < 4, (c >= 7) && !sel2, (c >= 7) && sel2, 1'b1);
            if (poke && c == 0) begin
                joystick_0 = '0;
                joystick_1 = '0;
            end
            if (poke && c == 4) joystick_1 = 16'h0100;
        end
        tick();
        chk_sys({name, ".rel"}, 0, 0, 0, 1);
        tick();
        chk_sys({name, ".hold"}, 0, 0, 0, 1);
        joystick_0 = '0;
        joystick_1 = '0;
        tick();
        chk_sys({name, ".idle"}, 0, 0, 0, 0);
    endtask
`endif

    typedef struct {
        logic [10:0] key;
        logic [15:0] j0;
        logic [15:0] j1;
        logic [6:0]  p1;
        logic [6:0]  p2;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{11'h775, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[1]  = '{11'h375, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[2]  = '{11'h375, 16'h0000, 16'h0000, 7'h08, 7'h00};
        tbl[3]  = '{11'h575, 16'h0000, 16'h0000, 7'h08, 7'h00};
        tbl[4]  = '{11'h575, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[5]  = '{11'h314, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[6]  = '{11'h314, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[7]  = '{11'h614, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[8]  = '{11'h614, 16'h0000, 16'h0000, 7'h10, 7'h00};
        tbl[9]  = '{11'h614, 16'h0001, 16'h0000, 7'h11, 7'h00};
        tbl[10] = '{11'h22D, 16'h0000, 16'h0000, 7'h10, 7'h00};
        tbl[11] = '{11'h22D, 16'h0000, 16'h0040, 7'h10, 7'h48};
        tbl[12] = '{11'h414, 16'h0000, 16'h0000, 7'h10, 7'h08};
        tbl[13] = '{11'h414, 16'h0000, 16'h0000, 7'h00, 7'h08};
        tbl[14] = '{11'h02D, 16'h0000, 16'h0000, 7'h00, 7'h08};
        tbl[15] = '{11'h02D, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[16] = '{11'h699, 16'h0000, 16'h0000, 7'h00, 7'h00};
        tbl[17] = '{11'h699, 16'h0000, 16'h0000, 7'h00, 7'h00};

        // Reset with toggle high and junk keys, then release: nothing may change
        ps2_key = 11'h775;
        m_keys  = '0;
        m_old   = 1'b0;
        do_reset(3);
        chk_sys("reset", 0, 0, 0, 0);
        chk("reset.p1", 32'(p1_ctrl), 32'(0));
        tick();
        chk_sys("post_reset", 0, 0, 0, 0);
        chk("post_reset.p1", 32'(p1_ctrl), 32'(0));

        for (int i = 0; i < 18; i++) begin
            ps2_key    = tbl[i].key;
            joystick_0 = tbl[i].j0;
            joystick_1 = tbl[i].j1;
            tick();
            chk($sformatf("vec%0d.p1", i), 32'(p1_ctrl), 32'(tbl[i].p1));
            chk($sformatf("vec%0d.p2", i), 32'(p2_ctrl), 32'(tbl[i].p2));
        end

        for (int n = 0; n < 400; n++) begin
            int idx;
            logic [7:0] code;
            idx = $urandom_range(0, 23);
            if (idx < NMAP) code = map_code[idx];
            else if (idx == 21) code = 8'h99;
            else if (idx == 22) code = 8'h00;
            else code = 8'h7C;
            ps2_key[10]  = ($urandom_range(0, 2) == 0) ? ~ps2_key[10] : ps2_key[10];
            ps2_key[9:0] = {1'($urandom), 1'($urandom), code};
            joystick_0   = 16'($urandom & $urandom & $urandom);
            joystick_1   = 16'($urandom & $urandom & $urandom);
            tick();
        end

        ps2_key = 11'h000;
        do_reset(2);
        tick();

`ifdef ARCADE_AUTO_COIN_EN
        joystick_0 = 16'h0080;
        run_seq("seq_p1", 1'b0, 1'b0);
        joystick_0 = 16'h0080;
        joystick_1 = 16'h0100;
        run_seq("seq_both", 1'b0, 1'b1);
        joystick_1 = 16'h0100;
        run_seq("seq_p2", 1'b1, 1'b0);

        joystick_0 = 16'h0080;
        for (int i = 0; i < 9; i++) tick();
        chk_sys("pre_abort", 0, 1, 0, 1);
        reset_n    = 1'b0;
        joystick_0 = '0;
        tick();
        chk_sys("abort", 0, 0, 0, 0);
        reset_n = 1'b1;
        tick();
        chk_sys("abort_idle", 0, 0, 0, 0);
        joystick_0 = 16'h0080;
        run_seq("seq_restart", 1'b0, 1'b0);
`else
        joystick_1 = 16'h0100;
        tick();
        chk_sys("joy1_start2", 0, 0, 1, 0);
        joystick_1 = '0;
        tick();
        chk_sys("joy1_start2_off", 0, 0, 0, 0);
        ps2_key = 11'h62E;
        tick();
        chk_sys("coin_key_evt", 0, 0, 0, 0);
        tick();
        chk_sys("coin_key_held", 1, 0, 0, 0);
        ps2_key = 11'h02E;
        tick();
        chk_sys("coin_key_rel_evt", 1, 0, 0, 0);
        tick();
        chk_sys("coin_key_off", 0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
